// File: rtl/alarm_ring_if.sv
// Alarm ring controller bus: comparator/button inputs
// plus buzzer and status outputs.
interface alarm_ring_if #(
  parameter int MAX_SNOOZE = 3
);
  localparam int UW =
    (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic          tick_1hz;
  logic          match;
  logic          alarm_en;
  logic          snooze_btn;
  logic          stop_btn;
  logic          buzzer;
  logic          ringing;
  logic          snoozing;
  logic [UW-1:0] snooze_used;

  modport master (
    output tick_1hz,
    output match,
    output alarm_en,
    output snooze_btn,
    output stop_btn,
    input  buzzer,
    input  ringing,
    input  snoozing,
    input  snooze_used
  );

  modport slave (
    input  tick_1hz,
    input  match,
    input  alarm_en,
    input  snooze_btn,
    input  stop_btn,
    output buzzer,
    output ringing,
    output snoozing,
    output snooze_used
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// Alarm buzzer sequencer: ring, snooze, auto-off
// and on/off beep pattern generation.
module alarm_ring_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  parameter int BEEP_CYCLES      = 25_000_000
) (
  input logic        clk,
  input logic        reset,
  alarm_ring_if.slave bus
);

  localparam int RW =
    (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int UW =
    (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int BW =
    (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  localparam logic [RW-1:0] RING_LAST =
    RW'(RING_TIMEOUT_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_SEC);
  localparam logic [UW-1:0] USED_MAX = UW'(MAX_SNOOZE);
  localparam logic [BW-1:0] BEEP_LAST =
    BW'(BEEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [UW-1:0] used_q, used_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          phase_q, phase_d;

  logic match_q, snz_btn_q, stop_btn_q;
  logic buzzer_q, ringing_q, snoozing_q;

  logic match_rise, snz_rise, stop_rise;

  assign match_rise = bus.match & ~match_q;
  assign snz_rise   = bus.snooze_btn & ~snz_btn_q;
  assign stop_rise  = bus.stop_btn & ~stop_btn_q;

  // Next-state, counter and beep-phase decode.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    used_d     = used_q;
    beep_cnt_d = beep_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      IDLE: begin
        if (match_rise && bus.alarm_en) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          used_d     = '0;
          beep_cnt_d = '0;
          phase_d    = 1'b1;
        end
      end
      RINGING: begin
        if (!bus.alarm_en || stop_rise) begin
          state_d = IDLE;
        end else begin
          if (snz_rise) begin
            // At the limit the press is swallowed.
            if (used_q < USED_MAX) begin
              state_d   = SNOOZE;
              snz_cnt_d = SNZ_LOAD;
              used_d    = used_q + 1'b1;
            end
          end else if (bus.tick_1hz) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d = IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q + 1'b1;
            end
          end
          if (state_d == RINGING) begin
            if (beep_cnt_q == BEEP_LAST) begin
              beep_cnt_d = '0;
              phase_d    = ~phase_q;
            end else begin
              beep_cnt_d = beep_cnt_q + 1'b1;
            end
          end
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en || stop_rise) begin
          state_d = IDLE;
        end else if (bus.tick_1hz) begin
          if (snz_cnt_q == SW'(1)) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            beep_cnt_d = '0;
            phase_d    = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      used_q     <= '0;
      beep_cnt_q <= '0;
      phase_q    <= 1'b0;
      match_q    <= 1'b1;
      snz_btn_q  <= 1'b1;
      stop_btn_q <= 1'b1;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      used_q     <= used_d;
      beep_cnt_q <= beep_cnt_d;
      phase_q    <= phase_d;
      match_q    <= bus.match;
      snz_btn_q  <= bus.snooze_btn;
      stop_btn_q <= bus.stop_btn;
      buzzer_q   <= (state_d == RINGING) & phase_d;
      ringing_q  <= (state_d == RINGING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_used = used_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed scoreboard bench for alarm_ring_controller
// with small timing parameters.
module tb_alarm_ring_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];

  alarm_ring_if #(.MAX_SNOOZE(2)) bus();

  alarm_ring_controller #(
    .SNOOZE_SEC      (3),
    .RING_TIMEOUT_SEC(5),
    .MAX_SNOOZE      (2),
    .BEEP_CYCLES     (4)
  ) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag,
                      input logic [4:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  // {ringing, snoozing, buzzer, snooze_used[1:0]}
  task automatic check();
    exp_t       it;
    logic [4:0] got;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=none exp=entry");
    end else begin
      it  = sb.pop_front();
      got = {bus.ringing, bus.snoozing,
             bus.buzzer, bus.snooze_used};
      assert (got === it.exp) else begin
        bad++;
        $error("FAIL %s got=%b exp=%b",
               it.tag, got, it.exp);
      end
    end
  endtask

  task automatic step(input logic tk,
                      input string tag,
                      input logic [4:0] e);
    bus.tick_1hz = tk;
    push(tag, e);
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    check();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    bus.tick_1hz   = 1'b0;
    bus.match      = 1'b0;
    bus.alarm_en   = 1'b1;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    #3;
    push("reset", 5'b00000);
    check();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ring, beep pattern, auto-off on 5th tick
    step(1'b0, "t1_idle", 5'b00000);
    bus.match = 1'b1;
    step(1'b0, "t1_ring", 5'b10100);
    for (int k = 1; k <= 14; k++) begin
      logic r;
      logic b;
      r = (k < 14);
      b = r & (((k / 4) % 2) == 0);
      step(((k % 3) == 2), "t1_beep",
           {r, 1'b0, b, 2'b00});
    end

    // 2: snooze (tick coincident, button wins)
    bus.match = 1'b0;
    step(1'b0, "t2_mlow", 5'b00000);
    bus.match = 1'b1;
    step(1'b0, "t2_ring", 5'b10100);
    bus.snooze_btn = 1'b1;
    step(1'b1, "t2_snz", 5'b01001);
    bus.snooze_btn = 1'b0;
    step(1'b0, "t2_wait", 5'b01001);
    step(1'b1, "t2_tk1", 5'b01001);
    step(1'b1, "t2_tk2", 5'b01001);
    step(1'b1, "t2_back", 5'b10101);

    // 3: second snooze, third is ignored
    bus.snooze_btn = 1'b1;
    step(1'b0, "t3_snz2", 5'b01010);
    bus.snooze_btn = 1'b0;
    step(1'b1, "t3_tk1", 5'b01010);
    step(1'b1, "t3_tk2", 5'b01010);
    step(1'b1, "t3_back", 5'b10110);
    bus.snooze_btn = 1'b1;
    step(1'b0, "t3_ign", 5'b10110);
    bus.snooze_btn = 1'b0;
    step(1'b0, "t3_hold", 5'b10110);

    // 4: stop with match high, no retrigger
    bus.stop_btn = 1'b1;
    step(1'b0, "t4_stop", 5'b00010);
    bus.stop_btn = 1'b0;
    for (int i = 0; i < 10; i++)
      step(1'b1, "t4_hold", 5'b00010);
    bus.match = 1'b0;
    step(1'b0, "t4_mlow", 5'b00010);
    bus.match = 1'b1;
    step(1'b0, "t4_rering", 5'b10100);

    // 5: stop+snooze together; alarm_en drop
    bus.stop_btn   = 1'b1;
    bus.snooze_btn = 1'b1;
    step(1'b0, "t5_both", 5'b00000);
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.match      = 1'b0;
    step(1'b0, "t5_mlow", 5'b00000);
    bus.match = 1'b1;
    step(1'b0, "t5_ring", 5'b10100);
    bus.snooze_btn = 1'b1;
    step(1'b0, "t5_snz", 5'b01001);
    bus.snooze_btn = 1'b0;
    bus.alarm_en   = 1'b0;
    step(1'b0, "t5_en_off", 5'b00001);
    bus.alarm_en = 1'b1;
    step(1'b0, "t5_idle", 5'b00001);

    // 6: reset with match high; async reset mid-ring
    #2;
    rst_n = 1'b0;
    #1;
    push("t6_rst", 5'b00000);
    check();
    rst_n = 1'b1;
    step(1'b0, "t6_noring", 5'b00000);
    bus.match = 1'b0;
    step(1'b0, "t6_mlow", 5'b00000);
    bus.match = 1'b1;
    step(1'b0, "t6_ring", 5'b10100);
    step(1'b0, "t6_ring2", 5'b10100);
    #2;
    rst_n = 1'b0;
    #1;
    push("t6_async", 5'b00000);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, "t6_after", 5'b00000);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
